// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with a two-entry skid buffer and a registered in_ready.
// Define MEM_WB_STAT_EN to build the saturating stall/bubble statistics counters.
module mem_wb_stage #(
    parameter int SW = 32,
    parameter int VW = 48,
    parameter int RW = 5,
    parameter int MW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [SW-1:0] in_alu,
    input  logic [SW-1:0] in_imm,
    input  logic [VW-1:0] in_mem,
    input  logic [VW-1:0] in_aluv,
    input  logic [RW-1:0] in_rd,
    input  logic [RW-1:0] in_vd,
    input  logic          in_rwe,
    input  logic [MW-1:0] in_m2r,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] out_alu,
    output logic [SW-1:0] out_imm,
    output logic [VW-1:0] out_mem,
    output logic [VW-1:0] out_aluv,
    output logic [RW-1:0] out_rd,
    output logic [RW-1:0] out_vd,
    output logic          out_rwe,
    output logic [MW-1:0] out_m2r,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   bubble_cnt
);

    typedef struct packed {
        logic [SW-1:0] alu;
        logic [SW-1:0] imm;
        logic [VW-1:0] mem;
        logic [VW-1:0] aluv;
        logic [RW-1:0] rd;
        logic [RW-1:0] vd;
        logic          rwe;
        logic [MW-1:0] m2r;
    } payload_t;

    payload_t in_pl;
    payload_t main_q, main_d, skid_q, skid_d;
    logic     main_valid_q, main_valid_d;
    logic     skid_valid_q, skid_valid_d;
    logic     accept, take;

    assign in_pl  = {in_alu, in_imm, in_mem, in_aluv, in_rd, in_vd, in_rwe, in_m2r};
    assign accept = in_valid && in_ready;
    assign take   = main_valid_q && out_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            // Kill only the valid bits; payloads keep their last contents.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (take || !main_valid_q) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = accept;
                if (accept) skid_d = in_pl;
            end else begin
                main_valid_d = accept;
                if (accept) main_d = in_pl;
            end
        end else if (accept) begin
            skid_d       = in_pl;
            skid_valid_d = 1'b1;
        end
    end

    // NOTE: payload registers are reset too (not just valids) so every out_* port reads 0 in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // in_ready comes straight from a flop, cutting any path from out_ready.
    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_alu   = main_q.alu;
    assign out_imm   = main_q.imm;
    assign out_mem   = main_q.mem;
    assign out_aluv  = main_q.aluv;
    assign out_rd    = main_q.rd;
    assign out_vd    = main_q.vd;
    assign out_rwe   = main_q.rwe && main_valid_q;
    assign out_m2r   = main_q.m2r;

`ifdef MEM_WB_STAT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (main_valid_q && !out_ready && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (!main_valid_q && bubble_cnt_q != 32'hFFFF_FFFF)
            bubble_cnt_d = bubble_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = 32'd0;
    assign bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus a randomized run against a
// two-deep FIFO reference model.
module tb_mem_wb_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] imm;
        logic [47:0] mem;
        logic [47:0] aluv;
        logic [4:0]  rd;
        logic [4:0]  vd;
        logic        rwe;
        logic [1:0]  m2r;
    } pl_t;

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, out_valid, out_ready;
    pl_t  drv, obs;
    logic [31:0] stall_cnt, bubble_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_alu     (drv.alu),
        .in_imm     (drv.imm),
        .in_mem     (drv.mem),
        .in_aluv    (drv.aluv),
        .in_rd      (drv.rd),
        .in_vd      (drv.vd),
        .in_rwe     (drv.rwe),
        .in_m2r     (drv.m2r),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_alu    (obs.alu),
        .out_imm    (obs.imm),
        .out_mem    (obs.mem),
        .out_aluv   (obs.aluv),
        .out_rd     (obs.rd),
        .out_vd     (obs.vd),
        .out_rwe    (obs.rwe),
        .out_m2r    (obs.m2r),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic pl_t rand_pl();
        pl_t p;
        p.alu  = $urandom;
        p.imm  = $urandom;
        p.mem  = {16'($urandom), $urandom};
        p.aluv = {16'($urandom), $urandom};
        p.rd   = 5'($urandom);
        p.vd   = 5'($urandom);
        p.rwe  = 1'($urandom);
        p.m2r  = 2'($urandom);
        return p;
    endfunction

    task automatic do_reset;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; drv = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; drv = '1;
        #3;
        tests_run++;
        if (obs !== '0) begin
            tests_failed++; $display("FAIL reset_payload: got %h want 0", obs);
        end
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        tests_run++;
        if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin
            tests_failed++; $display("FAIL reset_cnt: stall=%0d bubble=%0d want 0/0", stall_cnt, bubble_cnt);
        end
        tick;
        rst = 1'b0;
        drv = '0;
    endtask

    task automatic test_basic;
        do_reset;
        out_ready = 1'b1; in_valid = 1'b1;
        drv = '0; drv.alu = 32'h1234; drv.rd = 5'd7; drv.rwe = 1'b1;
        tick;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || obs.alu !== 32'h1234 || obs.rd !== 5'd7 || obs.rwe !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic: valid=%b alu=%h rd=%0d rwe=%b want 1/1234/7/1", out_valid, obs.alu, obs.rd, obs.rwe);
        end
        tick;
        tests_run++;
        if (out_valid !== 1'b0 || out_rwe_bit() !== 1'b0) begin
            tests_failed++; $display("FAIL basic_drain: valid=%b rwe=%b want 0/0", out_valid, obs.rwe);
        end
    endtask

    function automatic logic out_rwe_bit();
        return obs.rwe;
    endfunction

    task automatic test_back_to_back;
        do_reset;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; drv = rand_pl(); drv.alu = 32'd100 + 32'(i);
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready);
            end
            tick;
            tests_run++;
            if (out_valid !== 1'b1 || obs.alu !== 32'd100 + 32'(i)) begin
                tests_failed++;
                $display("FAIL b2b_out[%0d]: valid=%b alu=%0d want 1/%0d", i, out_valid, obs.alu, 100 + i);
            end
        end
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_backpressure;
        do_reset;
        out_ready = 1'b0; in_valid = 1'b1; drv = rand_pl(); drv.alu = 32'd1;
        tick;
        drv.alu = 32'd2;
        tick;
        drv.alu = 32'd3;
        tests_run++;
        if (in_ready !== 1'b0 || obs.alu !== 32'd1) begin
            tests_failed++; $display("FAIL bp_full: in_ready=%b alu=%0d want 0/1", in_ready, obs.alu);
        end
        tick;
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs.alu !== 32'd1) begin
            tests_failed++;
            $display("FAIL bp_hold: in_ready=%b valid=%b alu=%0d want 0/1/1", in_ready, out_valid, obs.alu);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick;
        tests_run++;
        if (out_valid !== 1'b1 || obs.alu !== 32'd2 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_drain2: valid=%b alu=%0d in_ready=%b want 1/2/1", out_valid, obs.alu, in_ready);
        end
        tick;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL bp_empty: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush;
        do_reset;
        out_ready = 1'b0; in_valid = 1'b1; drv = rand_pl(); drv.rwe = 1'b1;
        tick;
        drv.alu = 32'hA5A5_0002;
        tick;
        flush = 1'b1; drv.alu = 32'hDEAD_BEEF;
        tick;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tests_run++;
        if (out_valid !== 1'b0 || obs.rwe !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush: valid=%b rwe=%b in_ready=%b want 0/0/1", out_valid, obs.rwe, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++; $display("FAIL flush_dropped[%0d]: valid=%b alu=%h want 0", i, out_valid, obs.alu);
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        out_ready = 1'b0; in_valid = 1'b1; drv = rand_pl(); drv.rwe = 1'b1;
        tick;
        drv = rand_pl();
        tick;
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (obs !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid: payload=%h valid=%b in_ready=%b want 0/0/1", obs, out_valid, in_ready);
        end
        tick;
        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; drv = rand_pl(); drv.alu = 32'hC0FF_EE00;
        tick;
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || obs.alu !== 32'hC0FF_EE00) begin
            tests_failed++; $display("FAIL rst_resume: valid=%b alu=%h want 1/c0ffee00", out_valid, obs.alu);
        end
        tick;
    endtask

    task automatic test_stats;
        logic [31:0] exp_stall, exp_bubble;
`ifdef MEM_WB_STAT_EN
        exp_stall = 32'd5; exp_bubble = 32'd1;
`else
        exp_stall = 32'd0; exp_bubble = 32'd0;
`endif
        do_reset;
        out_ready = 1'b0; in_valid = 1'b1; drv = rand_pl();
        tick;
        in_valid = 1'b0;
        repeat (5) tick;
        tests_run++;
        if (stall_cnt !== exp_stall) begin
            tests_failed++; $display("FAIL stats_stall: got %0d want %0d", stall_cnt, exp_stall);
        end
        tests_run++;
        if (bubble_cnt !== exp_bubble) begin
            tests_failed++; $display("FAIL stats_bubble: got %0d want %0d", bubble_cnt, exp_bubble);
        end
    endtask

    // Reference: a FIFO of capacity 2; ready when it has room, head is the output.
    task automatic test_random;
        pl_t q[$];
        int  exp_stall = 0;
        int  exp_bubble = 0;
        int  errs = 0;
        bit  acc, tk;
        do_reset;
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            drv       = rand_pl();
            tests_run++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
                tests_failed++; errs++;
                if (errs < 10)
                    $display("FAIL rand_hs[%0d]: valid=%b in_ready=%b want %b/%b", c, out_valid, in_ready,
                             q.size() != 0, q.size() < 2);
            end else if (q.size() != 0 && obs !== q[0]) begin
                tests_failed++; errs++;
                if (errs < 10) $display("FAIL rand_data[%0d]: got %h want %h", c, obs, q[0]);
            end else if (q.size() == 0 && obs.rwe !== 1'b0) begin
                tests_failed++; errs++;
                if (errs < 10) $display("FAIL rand_rwe[%0d]: got %b want 0", c, obs.rwe);
            end
`ifdef MEM_WB_STAT_EN
            tests_run++;
            if (stall_cnt !== 32'(exp_stall) || bubble_cnt !== 32'(exp_bubble)) begin
                tests_failed++; errs++;
                if (errs < 10)
                    $display("FAIL rand_cnt[%0d]: stall=%0d bubble=%0d want %0d/%0d", c, stall_cnt, bubble_cnt,
                             exp_stall, exp_bubble);
            end
`endif
            if (q.size() != 0 && !out_ready) exp_stall++;
            if (q.size() == 0) exp_bubble++;
            acc = in_valid && (q.size() < 2);
            tk  = (q.size() != 0) && out_ready;
            if (flush) q.delete();
            else begin
                if (tk) void'(q.pop_front());
                if (acc) q.push_back(drv);
            end
            tick;
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; drv = '0;
        test_reset;
        test_basic;
        test_back_to_back;
        test_backpressure;
        test_flush;
        test_reset_mid;
        test_stats;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
